hilo_muldiv_unit: RTL and testbench
===================================

Name: hilo_muldiv_unit

Overview:
- Execute-stage multiply/divide unit that owns the architectural HI/LO registers.
- Sits beside the ALU. It consumes the E-stage operands and control (multordivE, hlwriteE-qualified start) and feeds HI/LO back to the datapath's mfhi/mflo path (mfhlW select).
- Multiply completes in one clock. Divide is iterative radix-2 restoring and raises busy so the hazard unit can stall F/D/E.

Parameters:
- WIDTH, 32, operand and HI/LO width; divide iteration count equals WIDTH.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- startE  input  1  start request; hlwriteE qualified by a valid, non-flushed E-stage instruction.
- multordivE  input  1  0 = multiply, 1 = divide.
- unsignedE  input  1  1 = multu/divu, 0 = signed mult/div.
- srcaE  input  WIDTH  multiplicand / dividend.
- srcbE  input  WIDTH  multiplier / divisor.
- hi  output  WIDTH  HI register (product upper half / remainder).
- lo  output  WIDTH  LO register (product lower half / quotient).
- busy  output  1  divide in progress; hazard unit stalls on it.
- done  output  1  one-cycle pulse in the cycle after HI/LO update.
- divzero  output  1  pulses with done when the divisor was zero.

Behaviour:
- Reset (async, any time including mid-divide):
  - state=IDLE, hi=0, lo=0, busy=0, done=0, divzero=0, iteration counter=0.
  - Any in-flight divide is discarded.
- States: IDLE, DIV, FIX.
- IDLE, startE=1, multordivE=0 (multiply):
  - At the sampling edge, {hi,lo} <= full 2*WIDTH product, signed or unsigned per unsignedE.
  - done=1 in the following cycle; busy never asserts; state stays IDLE.
- IDLE, startE=1, multordivE=1 (divide):
  - At the sampling edge, latch |dividend|, |divisor|, the quotient sign (signA XOR signB) and the remainder sign (signA). Signs are forced to 0 when unsignedE=1.
  - Counter=0; state=DIV; busy=1 from the next cycle.
- DIV:
  - Each edge produces one quotient bit, MSB first, via shift-subtract on the WIDTH+1-bit partial remainder.
  - After WIDTH iterations (edge WIDTH after start), state=FIX.
- FIX (one edge):
  - Apply signs: lo <= quotient, hi <= remainder, each two's-complement negated when its sign is set.
  - state=IDLE, busy=0 in the next cycle, done=1 for one cycle.
  - Total: HI/LO updated at edge WIDTH+1 after the start edge; busy high for WIDTH+1 cycles.
- Divisor zero:
  - Still runs the full WIDTH+1 cycles.
  - Result: lo=all ones, hi=original dividend (sign-preserved, unmodified); divzero pulses with done.
- Signed overflow (-2^(WIDTH-1) / -1): lo=0x80000000, hi=0, no flag.
- startE while busy: ignored. HI/LO and the divide in progress are unaffected; the hazard unit must keep the instruction stalled.
- HI/LO hold their values whenever no multiply/divide write occurs.
- Operands are only sampled at the start edge; later changes on srcaE/srcbE have no effect.

Test Plan:
- Signed mult: srcaE=0xFFFFFFFD (-3), srcbE=5 → next edge hi=0xFFFFFFFF, lo=0xFFFFFFF1; done=1 one cycle; busy=0 throughout.
- Unsigned mult: srcaE=0xFFFFFFFF, srcbE=2, unsignedE=1 → hi=0x00000001, lo=0xFFFFFFFE.
- Signed div -7/2: srcaE=0xFFFFFFF9, srcbE=2 →
  - busy=1 for exactly 33 cycles;
  - at edge 33, lo=0xFFFFFFFD, hi=0xFFFFFFFF;
  - done pulse; HI/LO unchanged before edge 33.
- Unsigned div 100/7 → lo=14, hi=2. A second startE pulsed at cycle 10 is ignored: result and latency unchanged, no extra done.
- Divide-by-zero 0x12345678/0 → after 33 cycles lo=0xFFFFFFFF, hi=0x12345678, divzero=1 with done. Also 0x80000000/0xFFFFFFFF signed → lo=0x80000000, hi=0, divzero=0.
- Reset asserted asynchronously mid-divide (cycle 15) → busy, hi, lo drop to 0 immediately. After release, IDLE accepts a new mult 6*7 → lo=42, hi=0.

Source files
------------

// File: rtl/hilo_muldiv_unit.sv
// HI/LO multiply/divide unit for the execute stage.
// Multiply writes {hi,lo} in a single clock. Divide is radix-2 restoring,
// one quotient bit per clock, followed by one clock of sign correction.
//
// State | Meaning
// ------+------------------------------------------------------------
// IDLE  | waiting for a start; multiplies complete here in one edge
// DIV   | shift-subtract iterations, one quotient bit per edge
// FIX   | apply quotient/remainder signs, write HI/LO, pulse done
module hilo_muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             startE,
    input  logic             multordivE,
    input  logic             unsignedE,
    input  logic [WIDTH-1:0] srcaE,
    input  logic [WIDTH-1:0] srcbE,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             divzero
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [CW-1:0]    LAST_IT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DIV  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [CW-1:0]      count;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   divisor;
    logic               q_sign;
    logic               r_sign;
    logic               dz;

    logic               start_mul;
    logic               start_div;
    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               b_zero;
    logic [2*WIDTH-1:0] a_ext;
    logic [2*WIDTH-1:0] b_ext;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH:0]     shifted;
    logic               fits;
    logic [WIDTH-1:0]   diff;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;

    // Starts are only honoured in IDLE; a start while busy is dropped.
    assign start_mul = (state == IDLE) && startE && !multordivE;
    assign start_div = (state == IDLE) && startE &&  multordivE;

    // Operand signs are ignored for the unsigned variants.
    assign sign_a = !unsignedE && srcaE[WIDTH-1];
    assign sign_b = !unsignedE && srcbE[WIDTH-1];
    assign abs_a  = sign_a ? (~srcaE + ONE) : srcaE;
    assign abs_b  = sign_b ? (~srcbE + ONE) : srcbE;
    assign b_zero = (srcbE == '0);

    // Sign-extending to 2*WIDTH makes the low 2*WIDTH product bits correct
    // for both signed and unsigned operands.
    assign a_ext   = {{WIDTH{sign_a}}, srcaE};
    assign b_ext   = {{WIDTH{sign_b}}, srcbE};
    assign product = a_ext * b_ext;

    // One restoring step: shift the next dividend bit into the WIDTH+1-bit
    // partial remainder and subtract when the divisor fits. After a
    // successful subtract the result is below the divisor, so WIDTH bits hold it.
    assign shifted = {rem, quo[WIDTH-1]};
    assign fits    = (shifted >= {1'b0, divisor});
    assign diff    = shifted[WIDTH-1:0] - divisor;

    assign quo_signed = q_sign ? (~quo + ONE) : quo;
    assign rem_signed = r_sign ? (~rem + ONE) : rem;

    assign busy = (state != IDLE);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start_div) begin
                    state_nxt = DIV;
                end
            end
            DIV: begin
                if (count == LAST_IT) begin
                    state_nxt = FIX;
                end
            end
            FIX: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Iteration counter: cleared at divide start, advanced once per DIV edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (start_div) begin
            count <= '0;
        end else if (state == DIV) begin
            count <= count + CW'(1);
        end
    end

    // Divide working registers: operands and signs latched at the start edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem     <= '0;
            quo     <= '0;
            divisor <= '0;
            q_sign  <= 1'b0;
            r_sign  <= 1'b0;
            dz      <= 1'b0;
        end else if (start_div) begin
            rem     <= '0;
            quo     <= abs_a;
            divisor <= abs_b;
            q_sign  <= sign_a ^ sign_b;
            r_sign  <= sign_a;
            dz      <= b_zero;
        end else if (state == DIV) begin
            rem     <= fits ? diff : shifted[WIDTH-1:0];
            quo     <= {quo[WIDTH-2:0], fits};
        end
    end

    // HI/LO architectural registers plus the done/divzero pulses.
    // A zero divisor leaves the remainder equal to |dividend|, so the
    // remainder sign restores the original dividend in HI; LO is forced
    // to all ones rather than letting the quotient sign flip it.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
            divzero <= 1'b0;
        end else begin
            done    <= 1'b0;
            divzero <= 1'b0;
            if (start_mul) begin
                hi   <= product[2*WIDTH-1:WIDTH];
                lo   <= product[WIDTH-1:0];
                done <= 1'b1;
            end else if (state == FIX) begin
                hi      <= rem_signed;
                lo      <= dz ? '1 : quo_signed;
                done    <= 1'b1;
                divzero <= dz;
            end
        end
    end

endmodule

// File: tb/tb_hilo_muldiv_unit.sv
// Scoreboard bench for hilo_muldiv_unit: stimulus pushes expected results,
// a monitor pops and compares whenever done is seen.
module tb_hilo_muldiv_unit;

    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             startE;
    logic             multordivE;
    logic             unsignedE;
    logic [WIDTH-1:0] srcaE;
    logic [WIDTH-1:0] srcbE;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             divzero;

    hilo_muldiv_unit #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .startE     (startE),
        .multordivE (multordivE),
        .unsignedE  (unsignedE),
        .srcaE      (srcaE),
        .srcbE      (srcbE),
        .hi         (hi),
        .lo         (lo),
        .busy       (busy),
        .done       (done),
        .divzero    (divzero)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          busy_cycles;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: counts busy cycles and checks every done against the scoreboard.
    int busy_run = 0;
    always @(negedge clk) begin : monitor
        exp_t e;
        if (reset) begin
            busy_run = 0;
        end else begin
            if (busy) busy_run++;
            if (done) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_done: got done=1 expected no pending result");
                end else begin
                    e = sb.pop_front();
                    check32({e.name, ".hi"}, hi, e.hi);
                    check32({e.name, ".lo"}, lo, e.lo);
                    check_int({e.name, ".divzero"}, int'(divzero), int'(e.dz));
                    check_int({e.name, ".busy_cycles"}, busy_run, e.busy_cycles);
                end
                busy_run = 0;
            end
        end
    end

    // Issue one operation; optionally pulse a stray multiply start at cycle
    // inject_at while the unit is busy. HI/LO must hold the previous result
    // for every busy cycle.
    task automatic run_op(input string name, input logic mdiv, input logic uns,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                          input logic exp_dz, input int inject_at);
        exp_t e;
        bit held;
        bit got;
        held          = 1'b1;
        got           = 1'b0;
        e.name        = name;
        e.hi          = exp_hi;
        e.lo          = exp_lo;
        e.dz          = exp_dz;
        e.busy_cycles = mdiv ? WIDTH + 1 : 0;
        @(negedge clk); #1;
        startE     = 1'b1;
        multordivE = mdiv;
        unsignedE  = uns;
        srcaE      = a;
        srcbE      = b;
        sb.push_back(e);
        @(negedge clk); #1;
        startE = 1'b0;
        srcaE  = 32'hA5A5_5A5A;
        srcbE  = 32'h0000_0003;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (sb.size() == 0) begin
                got = 1'b1;
                break;
            end
            if (busy && (hi !== model_hi || lo !== model_lo)) held = 1'b0;
            if (cyc == inject_at) begin
                startE     = 1'b1;
                multordivE = 1'b0;
                srcaE      = 32'd3;
                srcbE      = 32'd3;
            end else begin
                startE = 1'b0;
            end
            @(negedge clk); #1;
        end
        startE = 1'b0;
        if (!got) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s.timeout: got no done within 60 cycles expected done", name);
            sb.delete();
        end
        if (mdiv) check_int({name, ".hilo_hold"}, int'(held), 1);
        model_hi = exp_hi;
        model_lo = exp_lo;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        startE     = 1'b0;
        multordivE = 1'b0;
        unsignedE  = 1'b0;
        srcaE      = '0;
        srcbE      = '0;
        repeat (2) @(negedge clk);
        check32("reset.hi", hi, 32'h0);
        check32("reset.lo", lo, 32'h0);
        check_int("reset.busy", int'(busy), 0);
        check_int("reset.done", int'(done), 0);
        check_int("reset.divzero", int'(divzero), 0);
        #1 reset = 1'b0;

        //     name             div   uns   a              b              hi             lo             dz    inj
        run_op("mult_s_neg3x5", 1'b0, 1'b0, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1, 1'b0, 0);
        run_op("multu_max_x2",  1'b0, 1'b1, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE, 1'b0, 0);
        run_op("mult_s_n2xn3",  1'b0, 1'b0, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000000, 32'h00000006, 1'b0, 0);
        run_op("div_s_n7d2",    1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0);
        run_op("div_s_7dn2",    1'b1, 1'b0, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 0);
        run_op("divu_100d7",    1'b1, 1'b1, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 10);
        run_op("divu_max_d16",  1'b1, 1'b1, 32'hFFFFFFFF, 32'h00000010, 32'h0000000F, 32'h0FFFFFFF, 1'b0, 0);
        run_op("div_zero_pos",  1'b1, 1'b0, 32'h12345678, 32'h00000000, 32'h12345678, 32'hFFFFFFFF, 1'b1, 0);
        run_op("div_zero_neg",  1'b1, 1'b0, 32'hFFFFFFF9, 32'h00000000, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1, 0);
        run_op("div_s_ovf",     1'b1, 1'b0, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0);

        // Asynchronous reset in the middle of a divide.
        @(negedge clk); #1;
        startE     = 1'b1;
        multordivE = 1'b1;
        unsignedE  = 1'b1;
        srcaE      = 32'd1000;
        srcbE      = 32'd3;
        @(negedge clk); #1;
        startE = 1'b0;
        repeat (14) @(negedge clk);
        check_int("mid_div.busy", int'(busy), 1);
        #2 reset = 1'b1;
        #1;
        check_int("async_reset.busy", int'(busy), 0);
        check32("async_reset.hi", hi, 32'h0);
        check32("async_reset.lo", lo, 32'h0);
        @(negedge clk); #1;
        reset    = 1'b0;
        model_hi = '0;
        model_lo = '0;
        run_op("mult_after_rst", 1'b0, 1'b0, 32'd6, 32'd7, 32'h00000000, 32'd42, 1'b0, 0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
